sub64_pipe: RTL and testbench

SUB64_PIPE -- requirements
Module: sub64_pipe

---
 rtl/arith_pkg.sv | 21 ++
 rtl/ks_prefix_add.sv | 39 +++
 rtl/sub64_pipe.sv | 115 +++++++++++
 tb/tb_sub64_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: flag bit positions and the stage-1 payload of
// the pipelined subtractor.
package arith_pkg;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAGS_W   = 3;

    // Payload halves are sized for the widest supported operand (W <= 2*HALF_MAX);
    // narrower instances use only the low bits of each field.
    localparam int HALF_MAX  = 32;

    typedef struct packed {
        logic [HALF_MAX-1:0] lo;
        logic                carry;
        logic [HALF_MAX-1:0] a_hi;
        logic [HALF_MAX-1:0] nb_hi;
    } s1_payload_t;

endpackage

// File: rtl/ks_prefix_add.sv
// Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module ks_prefix_add #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int LV = $clog2(N);

    wire [N-1:0] g [0:LV];
    wire [N-1:0] p [0:LV];
    wire [N-1:0] p0;

    assign p0   = x ^ y;
    // Carry-in is folded into bit 0 so the prefix tree yields carries directly.
    assign g[0] = (x & y) | {{(N-1){1'b0}}, p0[0] & cin};
    assign p[0] = p0;

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int D = 1 << l;
        for (genvar i = 0; i < N; i++) begin : g_col
            if (i >= D) begin : g_merge
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
                assign p[l+1][i] = p[l][i] & p[l][i-D];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end

    assign s    = p0 ^ {g[LV][N-2:0], cin};
    assign cout = g[LV][N-1];

endmodule

// File: rtl/sub64_pipe.sv
// Two-stage pipelined subtractor d = a - b - bIn with valid/ready handshaking;
// low half resolved in stage 1, upper half and flags in stage 2.
module sub64_pipe
    import arith_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic                bIn,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [W-1:0]        d,
    output logic                bOut,
    output logic [FLAGS_W-1:0]  flags,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int HALF = W / 2;

    logic [W-1:0]         nb;
    logic [HALF-1:0]      lo_sum;
    logic                 lo_cout;
    logic [HALF-1:0]      hi_sum;
    logic                 hi_cout;
    s1_payload_t          s1_d;
    s1_payload_t          s1_q;
    logic                 s1_valid;
    logic                 s1_advance;
    logic                 in_fire;
    logic [W-1:0]         d_next;
    logic [FLAGS_W-1:0]   flags_next;
    logic                 a_msb;
    logic                 b_msb;

    assign nb = ~b;

    // Subtraction as a + ~b + ~bIn; the inverted borrow-in is the low carry-in.
    ks_prefix_add #(.N(HALF)) u_add_lo (
        .x    (a[HALF-1:0]),
        .y    (nb[HALF-1:0]),
        .cin  (~bIn),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.lo    = HALF_MAX'(lo_sum);
        s1_d.carry = lo_cout;
        s1_d.a_hi  = HALF_MAX'(a[W-1:HALF]);
        s1_d.nb_hi = HALF_MAX'(nb[W-1:HALF]);
    end

    ks_prefix_add #(.N(HALF)) u_add_hi (
        .x    (s1_q.a_hi[HALF-1:0]),
        .y    (s1_q.nb_hi[HALF-1:0]),
        .cin  (s1_q.carry),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    assign d_next = {hi_sum, s1_q.lo[HALF-1:0]};
    assign a_msb  = s1_q.a_hi[HALF-1];
    assign b_msb  = ~s1_q.nb_hi[HALF-1];

    always_comb begin
        flags_next            = '0;
        flags_next[FLAG_ZERO] = (d_next == '0);
        flags_next[FLAG_NEG]  = d_next[W-1];
        flags_next[FLAG_OVF]  = (a_msb != b_msb) & (d_next[W-1] != a_msb);
    end

    // The output register frees up whenever it is empty or being popped, which
    // makes in_ready combinationally dependent on out_ready.
    assign s1_advance = s1_valid & (~out_valid | out_ready);
    assign in_ready   = ~s1_valid | s1_advance;
    assign in_fire    = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            d         <= '0;
            bOut      <= 1'b0;
            flags     <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            d         <= d_next;
            bOut      <= ~hi_cout;
            flags     <= flags_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub64_pipe.sv
// Directed and random bench for sub64_pipe; expected results come from a
// wide-integer reference model queued at acceptance and checked at output.
module tb_sub64_pipe;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic [2:0]   flags;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bIn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d;
    logic         bOut;
    logic [2:0]   flags;
    logic         out_valid;
    logic         out_ready;
    logic         rdy_dir;
    logic         rand_mode;
    logic         rand_bit;

    res_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    sub64_pipe #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .bIn       (bIn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bOut      (bOut),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1 rand_bit = 1'($urandom_range(0, 1));
    end

    assign out_ready = rand_mode ? rand_bit : rdy_dir;

    function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        res_t         r;
        logic [W:0]   full;
        full       = {1'b0, ta} - {1'b0, tb_} - {{W{1'b0}}, tbin};
        r.d        = full[W-1:0];
        r.bout     = full[W];
        r.flags[2] = (ta[W-1] != tb_[W-1]) && (r.d[W-1] != ta[W-1]);
        r.flags[1] = r.d[W-1];
        r.flags[0] = (r.d == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every output handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            res_t e;
            chk("sb_nonempty", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_d", d, e.d);
                chk("out_bout", W'(bOut), W'(e.bout));
                chk("out_flags", W'(flags), W'(e.flags));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        int n = 0;
        a        = ta;
        b        = tb_;
        bIn      = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("in_ready_timeout", W'(in_ready), W'(1));
        end else begin
            sb.push_back(model(ta, tb_, tbin));
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        bIn      = 1'($urandom_range(0, 1));
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_empty", W'(sb.size()), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           c0;

        reset     = 1'b1;
        rand_mode = 1'b0;
        rdy_dir   = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bIn       = 1'b0;

        #2;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_d", d, W'(0));
        chk("rst_bout", W'(bOut), W'(0));
        chk("rst_flags", W'(flags), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Latency: result appears after the second edge following presentation.
        send(64'd40, 64'd20, 1'b0);
        @(negedge clk);
        chk("lat_not_yet", W'(out_valid), W'(0));
        @(negedge clk);
        chk("lat_valid", W'(out_valid), W'(1));
        chk("lat_d", d, W'(20));
        @(posedge clk);
        idle(2);

        send(64'd0, 64'd1, 1'b0);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        send(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1);
        send(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd5, 64'd4, 1'b1);
        idle(4);
        drain();

        // Back-pressure: two beats fill the pipe, the third stalls until release.
        idle(1);
        rdy_dir = 1'b0;
        send(64'd100, 64'd7, 1'b0);
        send(64'd3, 64'd9, 1'b1);
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        bIn      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", W'(in_ready), W'(0));
        chk("stall_out_valid", W'(out_valid), W'(1));
        @(negedge clk);
        chk("stall_hold_ready", W'(in_ready), W'(0));
        chk("stall_hold_d", d, sb[0].d);
        chk("stall_hold_flags", W'(flags), W'(sb[0].flags));
        @(posedge clk);
        #1 rdy_dir = 1'b1;
        @(negedge clk);
        chk("release_in_ready", W'(in_ready), W'(1));
        sb.push_back(model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Throughput: eight back-to-back beats take eight cycles.
        idle(1);
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(W'(i * 1000 + 17), W'(i * 333), 1'(i));
        end
        chk("throughput", W'(cyc - c0), W'(8));
        drain();

        // Reset with both stages full.
        idle(1);
        rdy_dir = 1'b0;
        send(64'd77, 64'd11, 1'b0);
        send(64'd88, 64'd99, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_d", d, W'(0));
        chk("midrst_flags", W'(flags), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        rdy_dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", W'(out_valid), W'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic with random downstream readiness.
        rand_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {ra[W-1:W/2], $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
